// File: rtl/data_interface_mp.sv
// Multi-port data-storage interface: one write port, NUM_RD read ports, in-order request FIFO
// served by a latency-model FSM. Optional statistics counters under `define DATAIF_STATS_EN.
module data_interface_mp #(
  parameter int NUM_RD    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int ID_W      = 4,
  parameter int Q_DEPTH   = 16,
  parameter int BASE_LAT  = 2,
  parameter int LAT_SHIFT = 2,
  localparam int CNT_W    = $clog2(Q_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*ID_W-1:0]   rd_req_id,
  input  logic [NUM_RD*ID_W-1:0]   rd_recv_id,
  output logic                     rd_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic [ID_W-1:0]          rsp_req_id,
  output logic [ID_W-1:0]          rsp_recv_id,
  output logic [CNT_W-1:0]         q_count
`ifdef DATAIF_STATS_EN
  ,
  output logic [31:0]              stat_reads,
  output logic [31:0]              stat_writes,
  output logic [15:0]              stat_drops,
  output logic [CNT_W-1:0]         stat_max_occ
`endif
);

  localparam int PTR_W   = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int ENT_W   = ADDR_W + 2 * ID_W;
  localparam int LAT_MAX = BASE_LAT + (Q_DEPTH >> LAT_SHIFT);
  localparam int LAT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [DATA_W-1:0] storage [2**ADDR_W];
  logic [ENT_W-1:0]  q_mem [Q_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  q_count_reg;
  state_t            state_reg, state_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_next;
  logic              pop;

  logic [NUM_RD-1:0] accept;
  logic [CNT_W-1:0]  pre [NUM_RD+1];
  logic [PTR_W-1:0]  slot [NUM_RD];
  logic [ENT_W-1:0]  entry [NUM_RD];

  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] pop_data;

  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic [ID_W-1:0]   s1_req_reg, s1_recv_reg;

  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [ADDR_W-1:0] rsp_addr_reg;
  logic [ID_W-1:0]   rsp_req_reg, rsp_recv_reg;

  // Free space ignores a same-cycle pop so the ready decision depends on q_count alone.
  assign rd_ready = (Q_DEPTH - int'(q_count_reg)) >= NUM_RD;
  assign accept   = rd_ready ? rd_valid : '0;
  assign q_count  = q_count_reg;

  // Prefix count of accepted ports gives each port its slot, port 0 first.
  assign pre[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      assign pre[gi+1]  = pre[gi] + CNT_W'(accept[gi]);
      assign slot[gi]   = wr_ptr_reg + PTR_W'(pre[gi]);
      assign entry[gi]  = {rd_addr[gi*ADDR_W +: ADDR_W],
                           rd_req_id[gi*ID_W +: ID_W],
                           rd_recv_id[gi*ID_W +: ID_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (accept[i]) q_mem[slot[i]] <= entry[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      q_count_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_reg + PTR_W'(pre[NUM_RD]);
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      q_count_reg <= q_count_reg + pre[NUM_RD] - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) storage[i] <= '0;
    end else if (wr_valid) begin
      storage[wr_addr] <= wr_data;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      lat_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (q_count_reg != '0 && !halt) state_next = S_WAIT;
      S_WAIT: if (!halt && lat_cnt_reg == '0 && q_count_reg == CNT_W'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs (pop strobe and latency counter update)
  always_comb begin
    pop      = 1'b0;
    lat_next = lat_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (q_count_reg != '0 && !halt)
          lat_next = LAT_W'(BASE_LAT + (int'(q_count_reg) >> LAT_SHIFT));
      end
      S_WAIT: begin
        if (!halt) begin
          if (lat_cnt_reg != '0) begin
            lat_next = lat_cnt_reg - 1'b1;
          end else begin
            pop      = 1'b1;
            lat_next = LAT_W'(BASE_LAT + ((int'(q_count_reg) - 1) >> LAT_SHIFT));
          end
        end
      end
      default: lat_next = '0;
    endcase
  end

  // Write-first: a write landing on the pop edge is what the read returns.
  assign head      = q_mem[rd_ptr_reg];
  assign head_addr = head[ENT_W-1 -: ADDR_W];
  assign pop_data  = (wr_valid && wr_addr == head_addr) ? wr_data : storage[head_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg  <= 1'b0;
      s1_data_reg   <= '0;
      s1_addr_reg   <= '0;
      s1_req_reg    <= '0;
      s1_recv_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_addr_reg  <= '0;
      rsp_req_reg   <= '0;
      rsp_recv_reg  <= '0;
    end else begin
      s1_valid_reg  <= pop;
      s1_data_reg   <= pop ? pop_data : '0;
      s1_addr_reg   <= pop ? head_addr : '0;
      s1_req_reg    <= pop ? head[2*ID_W-1 -: ID_W] : '0;
      s1_recv_reg   <= pop ? head[ID_W-1:0] : '0;
      rsp_valid_reg <= s1_valid_reg;
      rsp_data_reg  <= s1_data_reg;
      rsp_addr_reg  <= s1_addr_reg;
      rsp_req_reg   <= s1_req_reg;
      rsp_recv_reg  <= s1_recv_reg;
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_addr    = rsp_addr_reg;
  assign rsp_req_id  = rsp_req_reg;
  assign rsp_recv_id = rsp_recv_reg;

`ifdef DATAIF_STATS_EN
  logic [31:0]      stat_reads_reg, stat_writes_reg;
  logic [15:0]      stat_drops_reg;
  logic [CNT_W-1:0] stat_max_reg;
  int               drop_inc;

  assign drop_inc = rd_ready ? 0 : $countones(rd_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads_reg  <= '0;
      stat_writes_reg <= '0;
      stat_drops_reg  <= '0;
      stat_max_reg    <= '0;
    end else begin
      if (s1_valid_reg && stat_reads_reg != 32'hFFFF_FFFF) stat_reads_reg <= stat_reads_reg + 1'b1;
      if (wr_valid && stat_writes_reg != 32'hFFFF_FFFF) stat_writes_reg <= stat_writes_reg + 1'b1;
      if (int'(stat_drops_reg) + drop_inc > 65535) stat_drops_reg <= 16'hFFFF;
      else stat_drops_reg <= stat_drops_reg + 16'(drop_inc);
      if (q_count_reg > stat_max_reg) stat_max_reg <= q_count_reg;
    end
  end

  assign stat_reads   = stat_reads_reg;
  assign stat_writes  = stat_writes_reg;
  assign stat_drops   = stat_drops_reg;
  assign stat_max_occ = stat_max_reg;
`endif

endmodule
